// File: rtl/static_lookup_table.sv
// static_lookup_table: runtime-writable source-tuple forwarding table, 2-stage pipeline, saturating hit/miss counters
module static_lookup_table #(
  parameter int C_NUM_PORTS      = 6,
  parameter int C_DMA_PORT       = 5,
  parameter int C_NUM_VPORTS     = 8,
  parameter int C_LAST_EXT_PORT  = 4,
  parameter int C_BRIDGE_A_VPORT = 5,
  parameter int C_BRIDGE_B_VPORT = 6,
  parameter int C_OUT_PORT_WIDTH = 8,
  parameter int C_ADDR_WIDTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tuple_valid,
  input  logic [2:0]                  tuple_port,
  input  logic [2:0]                  tuple_vport,
  input  logic                        cfg_wr_en,
  input  logic [C_ADDR_WIDTH-1:0]     cfg_wr_addr,
  input  logic [7:0]                  cfg_wr_data,
  input  logic                        cfg_cnt_clear,
  output logic                        action_valid,
  output logic                        action_match,
  output logic [C_OUT_PORT_WIDTH-1:0] action_port,
  output logic [C_OUT_PORT_WIDTH-1:0] action_vport,
  output logic [1:0]                  action_type,
  output logic [C_ADDR_WIDTH-1:0]     action_match_addr,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);
  localparam int N  = C_NUM_PORTS + C_NUM_VPORTS;
  localparam int OW = C_OUT_PORT_WIDTH;
  localparam int AW = C_ADDR_WIDTH;

  function automatic logic [7:0] def_entry(int i);
    int v;
    v = i - C_NUM_PORTS;
    def_entry = 8'h00;
    if (i <= C_LAST_EXT_PORT) def_entry = {2'd2, 3'(i), 3'(C_DMA_PORT)};
    else if (i >= C_NUM_PORTS && v <= C_LAST_EXT_PORT) def_entry = {2'd1, 3'd0, 3'(v)};
    else if (i >= C_NUM_PORTS && v == C_BRIDGE_A_VPORT) def_entry = {2'd2, 3'(C_BRIDGE_B_VPORT), 3'(C_DMA_PORT)};
    else if (i >= C_NUM_PORTS && v == C_BRIDGE_B_VPORT) def_entry = {2'd2, 3'(C_BRIDGE_A_VPORT), 3'(C_DMA_PORT)};
  endfunction

  logic [7:0]    tbl_q [N];
  logic          s1_v_q, s1_in_q, in_d, dma;
  logic [AW-1:0] s1_idx_q, idx_d;
  logic [7:0]    s1_e_q;
  logic          v_q, m_q, m_d;
  logic [OW-1:0] port_q, port_d, vport_q, vport_d;
  logic [1:0]    type_q, type_d, t;
  logic [AW-1:0] addr_q;
  logic [31:0]   hit_q, hit_d, miss_q, miss_d;

  // Table index and range check for the incoming tuple
  always_comb begin
    dma   = int'(tuple_port) == C_DMA_PORT;
    in_d  = int'(tuple_port) < C_NUM_PORTS && (!dma || int'(tuple_vport) < C_NUM_VPORTS);
    idx_d = !in_d ? '0 : dma ? AW'(C_NUM_PORTS + int'(tuple_vport)) : AW'(tuple_port);
  end

  // One-hot decode of the S1 entry and saturating counter next state
  always_comb begin
    t       = s1_e_q[7:6];
    m_d     = s1_in_q && (t == 2'd1 || t == 2'd2);
    port_d  = m_d ? OW'(1) << s1_e_q[2:0] : '0;
    vport_d = (m_d && t == 2'd2) ? OW'(1) << s1_e_q[5:3] : '0;
    type_d  = s1_in_q ? t : 2'd0;
    hit_d   = cfg_cnt_clear ? 32'd0 : (v_q && m_q && !(&hit_q)) ? hit_q + 32'd1 : hit_q;
    miss_d  = cfg_cnt_clear ? 32'd0 : (v_q && !m_q && !(&miss_q)) ? miss_q + 32'd1 : miss_q;
  end

  // Forwarding table: defaults on reset, config writes to in-range entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= def_entry(i);
    end else if (cfg_wr_en && int'(cfg_wr_addr) < N) begin
      tbl_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Pipeline stages and counters; S1 reads the pre-write table value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q   <= 1'b0;
      s1_in_q  <= 1'b0;
      s1_idx_q <= '0;
      s1_e_q   <= '0;
      v_q      <= 1'b0;
      m_q      <= 1'b0;
      port_q   <= '0;
      vport_q  <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      s1_v_q <= tuple_valid;
      if (tuple_valid) begin
        s1_in_q  <= in_d;
        s1_idx_q <= idx_d;
        s1_e_q   <= in_d ? tbl_q[idx_d] : 8'h00;
      end
      v_q <= s1_v_q;
      m_q <= s1_v_q && m_d;
      if (s1_v_q) begin
        port_q  <= port_d;
        vport_q <= vport_d;
        type_q  <= type_d;
        addr_q  <= s1_idx_q;
      end
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign action_valid      = v_q;
  assign action_match      = m_q;
  assign action_port       = port_q;
  assign action_vport      = vport_q;
  assign action_type       = type_q;
  assign action_match_addr = addr_q;
  assign hit_count         = hit_q;
  assign miss_count        = miss_q;
endmodule

// File: tb/tb_static_lookup_table.sv
// tb_static_lookup_table: directed checks of lookup defaults, pipelining, config writes, counters and reset
module tb_static_lookup_table;
  logic       clk = 1'b0;
  logic       reset;
  logic       tuple_valid;
  logic [2:0] tuple_port, tuple_vport;
  logic       cfg_wr_en;
  logic [3:0] cfg_wr_addr;
  logic [7:0] cfg_wr_data;
  logic       cfg_cnt_clear;
  logic       action_valid, action_match;
  logic [7:0] action_port, action_vport;
  logic [1:0] action_type;
  logic [3:0] action_match_addr;
  logic [31:0] hit_count, miss_count;
  int tests = 0;
  int fails = 0;
  static_lookup_table dut (
    .clk(clk), .reset(reset), .tuple_valid(tuple_valid), .tuple_port(tuple_port),
    .tuple_vport(tuple_vport), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_cnt_clear(cfg_cnt_clear), .action_valid(action_valid),
    .action_match(action_match), .action_port(action_port), .action_vport(action_vport),
    .action_type(action_type), .action_match_addr(action_match_addr),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] p, input logic [2:0] vp);
    tuple_valid = v;
    tuple_port  = p;
    tuple_vport = vp;
  endtask
  initial begin
    reset = 1'b0;
    drive(0, 0, 0);
    cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_data = 0; cfg_cnt_clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", action_valid, 1'b0);
    chk("rst_port", action_port, 8'h00);
    chk("rst_hit", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    reset = 1'b1;
    @(negedge clk); drive(1, 3'd2, 0);
    @(negedge clk); drive(0, 0, 0);
    chk("p2_lat1_valid", action_valid, 1'b0);
    @(negedge clk);
    chk("p2_valid", action_valid, 1'b1);
    chk("p2_match", action_match, 1'b1);
    chk("p2_port", action_port, 8'h20);
    chk("p2_vport", action_vport, 8'h04);
    chk("p2_type", action_type, 2'd2);
    chk("p2_addr", action_match_addr, 4'd2);
    @(negedge clk);
    chk("idle_valid", action_valid, 1'b0);
    chk("idle_match", action_match, 1'b0);
    chk("idle_hold_port", action_port, 8'h20);
    chk("hit_after_p2", hit_count, 32'd1);
    @(negedge clk); drive(1, 3'd5, 3'd5);
    @(negedge clk); drive(1, 3'd5, 3'd6);
    @(negedge clk); drive(0, 0, 0);
    chk("br_a_vport", action_vport, 8'h40);
    chk("br_a_port", action_port, 8'h20);
    chk("br_a_addr", action_match_addr, 4'd11);
    @(negedge clk);
    chk("br_b_valid", action_valid, 1'b1);
    chk("br_b_vport", action_vport, 8'h20);
    chk("br_b_port", action_port, 8'h20);
    chk("br_b_addr", action_match_addr, 4'd12);
    @(negedge clk); drive(1, 3'd5, 3'd3);
    cfg_wr_en = 1; cfg_wr_addr = 4'd9; cfg_wr_data = 8'h41;
    @(negedge clk); cfg_wr_en = 0;
    @(negedge clk); drive(0, 0, 0);
    chk("wr_old_port", action_port, 8'h08);
    chk("wr_old_vport", action_vport, 8'h00);
    chk("wr_old_type", action_type, 2'd1);
    @(negedge clk);
    chk("wr_new_port", action_port, 8'h02);
    chk("wr_new_type", action_type, 2'd1);
    cfg_cnt_clear = 1;
    @(negedge clk); cfg_cnt_clear = 0;
    chk("clr_hit", hit_count, 32'd0);
    chk("clr_miss", miss_count, 32'd0);
    @(negedge clk); drive(1, 3'd7, 3'd0);
    @(negedge clk); drive(1, 3'd5, 3'd7);
    @(negedge clk); drive(0, 0, 0);
    chk("oor_valid", action_valid, 1'b1);
    chk("oor_match", action_match, 1'b0);
    chk("oor_port", action_port, 8'h00);
    chk("oor_vport", action_vport, 8'h00);
    chk("oor_addr", action_match_addr, 4'd0);
    @(negedge clk);
    chk("v7_match", action_match, 1'b0);
    chk("v7_port", action_port, 8'h00);
    chk("v7_vport", action_vport, 8'h00);
    chk("v7_addr", action_match_addr, 4'd13);
    @(negedge clk);
    chk("miss_two", miss_count, 32'd2);
    chk("hit_zero", hit_count, 32'd0);
    force dut.hit_q = 32'hFFFFFFFE;
    #1 release dut.hit_q;
    @(negedge clk); drive(1, 3'd0, 0);
    @(negedge clk); drive(1, 3'd1, 0);
    @(negedge clk); drive(1, 3'd2, 0);
    @(negedge clk); drive(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("hit_sat", hit_count, 32'hFFFFFFFF);
    @(negedge clk); drive(1, 3'd0, 0);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk);
    chk("clr_race_valid", action_match, 1'b1);
    cfg_cnt_clear = 1;
    @(negedge clk); cfg_cnt_clear = 0;
    chk("clr_race_hit", hit_count, 32'd0);
    @(negedge clk);
    chk("clr_race_hit2", hit_count, 32'd0);
    @(negedge clk); drive(1, 3'd5, 3'd3);
    @(negedge clk); drive(0, 0, 0); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_flight_valid", action_valid, 1'b0);
      @(negedge clk);
    end
    drive(1, 3'd5, 3'd3);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk);
    chk("post_rst_valid", action_valid, 1'b1);
    chk("post_rst_port", action_port, 8'h08);
    chk("post_rst_type", action_type, 2'd1);
    chk("post_rst_miss", miss_count, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
